// File: rtl/unidad_riesgos_if.sv
// ID-stage hazard inputs and EX operand-select / stall outputs of the hazard unit.
// The slave side is the hazard unit; the master side is the surrounding pipeline.
interface unidad_riesgos_if #(
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
);
    logic          id_valid;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic          id_usa_rs;
    logic          id_usa_rt;
    logic [RW-1:0] id_rd;
    logic          id_regwrite;
    logic          id_memread;
    logic          flush;

    logic [1:0]       sel_a;
    logic [1:0]       sel_b;
    logic             stall;
    logic             burbuja;
    logic [CNT_W-1:0] cnt_stalls;

    modport slave (
        input  id_valid, id_rs, id_rt, id_usa_rs, id_usa_rt,
        input  id_rd, id_regwrite, id_memread, flush,
        output sel_a, sel_b, stall, burbuja, cnt_stalls
    );

    modport master (
        output id_valid, id_rs, id_rt, id_usa_rs, id_usa_rt,
        output id_rd, id_regwrite, id_memread, flush,
        input  sel_a, sel_b, stall, burbuja, cnt_stalls
    );
endinterface

// File: rtl/unidad_riesgos.sv
// Forwarding and load-use hazard control for a 5-stage pipeline.
// Keeps a shadow copy of the EX/MEM/WB destinations to drive the EX operand muxes.
module unidad_riesgos #(
    parameter int unsigned RW    = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    unidad_riesgos_if.slave    bus
);

    typedef struct packed {
        logic          v;
        logic [RW-1:0] rd;
        logic          rw;
        logic          mr;
    } etapa_t;

    typedef struct packed {
        etapa_t        e;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic          ua;
        logic          ub;
    } etapa_ex_t;

    etapa_ex_t        ex_q, ex_d;
    etapa_t           mem_q, mem_d;
    etapa_t           wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic carga_uso;
    logic stall_c;
    logic burbuja_c;

    // Register 0 is hard-wired, so a write to it is never a forwarding source.
    function automatic logic acierta(input etapa_t s, input logic [RW-1:0] x);
        return s.v && s.rw && (s.rd != '0) && (s.rd == x);
    endfunction

    // MEM holds the newer value, so it wins over WB.
    function automatic logic [1:0] selecciona(input logic          usa,
                                              input logic [RW-1:0] x,
                                              input etapa_t        m,
                                              input etapa_t        w);
        if (usa && acierta(m, x)) return 2'b10;
        if (usa && acierta(w, x)) return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ex_d      = '0;
        mem_d     = ex_q.e;
        wb_d      = mem_q;
        cnt_d     = cnt_q;
        carga_uso = ex_q.e.v && ex_q.e.mr && (ex_q.e.rd != '0) && bus.id_valid &&
                    ((bus.id_usa_rs && (ex_q.e.rd == bus.id_rs)) ||
                     (bus.id_usa_rt && (ex_q.e.rd == bus.id_rt)));
        // A flushed ID instruction is discarded, so it cannot need a stall.
        stall_c   = carga_uso && !bus.flush;
        burbuja_c = stall_c || bus.flush;

        if (bus.id_valid && !burbuja_c) begin
            ex_d.e.v  = 1'b1;
            ex_d.e.rd = bus.id_rd;
            ex_d.e.rw = bus.id_regwrite;
            ex_d.e.mr = bus.id_memread;
            ex_d.rs   = bus.id_rs;
            ex_d.rt   = bus.id_rt;
            ex_d.ua   = bus.id_usa_rs;
            ex_d.ub   = bus.id_usa_rt;
        end

        if (stall_c && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        bus.sel_a      = selecciona(ex_q.ua, ex_q.rs, mem_q, wb_q);
        bus.sel_b      = selecciona(ex_q.ub, ex_q.rt, mem_q, wb_q);
        bus.stall      = stall_c;
        bus.burbuja    = burbuja_c;
        bus.cnt_stalls = cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_unidad_riesgos.sv
// Directed bench for unidad_riesgos: the driver queues the expected outputs of each
// cycle and an independent negedge monitor pops and compares them.
module tb_unidad_riesgos;

    localparam int unsigned RW = 5;
    localparam int unsigned CW = 4;

    typedef struct {
        logic          chk;
        logic [1:0]    sa;
        logic [1:0]    sb;
        logic          st;
        logic          bu;
        logic [CW-1:0] cnt;
        string         nm;
    } esperado_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    esperado_t cola[$];
    esperado_t em;

    unidad_riesgos_if #(.RW(RW), .CNT_W(CW)) bus ();

    unidad_riesgos #(.RW(RW), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are stable mid-cycle, one queued expectation per cycle.
    always @(negedge clk) begin
        if (cola.size() != 0) begin
            em = cola.pop_front();
            if (em.chk) begin
                checks++;
                if (bus.sel_a !== em.sa || bus.sel_b !== em.sb || bus.stall !== em.st ||
                    bus.burbuja !== em.bu || bus.cnt_stalls !== em.cnt) begin
                    errors++;
                    $display("FAIL %s: got sel_a=%b sel_b=%b stall=%b burbuja=%b cnt=%0d, want sel_a=%b sel_b=%b stall=%b burbuja=%b cnt=%0d",
                             em.nm, bus.sel_a, bus.sel_b, bus.stall, bus.burbuja, bus.cnt_stalls,
                             em.sa, em.sb, em.st, em.bu, em.cnt);
                end
            end
        end
    end

    task automatic ciclo(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                         input logic ua, input logic ub, input logic [RW-1:0] rd,
                         input logic rw, input logic mr, input logic fl,
                         input logic chk, input logic [1:0] sa, input logic [1:0] sb,
                         input logic st, input logic bu, input logic [CW-1:0] cnt,
                         input string nm);
        esperado_t e;
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_usa_rs   = ua;
        bus.id_usa_rt   = ub;
        bus.id_rd       = rd;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
        bus.flush       = fl;
        e.chk = chk; e.sa = sa; e.sb = sb; e.st = st; e.bu = bu; e.cnt = cnt; e.nm = nm;
        cola.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // ALU op rd <= rs op rt, reads both sources.
    task automatic alu(input logic [RW-1:0] rd, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [1:0] sa, input logic [1:0] sb, input logic st,
                       input logic bu, input logic [CW-1:0] cnt, input string nm);
        ciclo(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b1, sa, sb, st, bu, cnt, nm);
    endtask

    // Load rd <= mem[rs], reads only rs.
    task automatic lw(input logic [RW-1:0] rd, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [CW-1:0] cnt, input string nm);
        ciclo(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0, 1'b1, sa, sb, 1'b0, 1'b0, cnt, nm);
    endtask

    task automatic nop(input logic [1:0] sa, input logic [1:0] sb, input logic [CW-1:0] cnt,
                       input string nm);
        ciclo(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, sa, sb, 1'b0, 1'b0, cnt, nm);
    endtask

    function automatic logic [CW-1:0] sat(input int n);
        return (n >= (1 << CW) - 1) ? '1 : CW'(n);
    endfunction

    initial begin
        bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rt = '0; bus.id_usa_rs = 1'b0;
        bus.id_usa_rt = 1'b0; bus.id_rd = '0; bus.id_regwrite = 1'b0;
        bus.id_memread = 1'b0; bus.flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nop(2'b00, 2'b00, 4'd0, "reset_state");
        reset = 1'b0;

        // 1: back-to-back dependency forwards from MEM
        alu(5'd3, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t1_producer_id");
        alu(5'd4, 5'd3, 5'd1, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t1_consumer_id");
        nop(2'b10, 2'b00, 4'd0, "t1_fwd_mem");
        nop(2'b00, 2'b00, 4'd0, "t1_drain0");
        nop(2'b00, 2'b00, 4'd0, "t1_drain1");

        // 2: one instruction apart forwards from WB; MEM beats WB
        alu(5'd3, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t2_producer");
        nop(2'b00, 2'b00, 4'd0, "t2_gap");
        alu(5'd5, 5'd1, 5'd3, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t2_consumer_id");
        nop(2'b00, 2'b01, 4'd0, "t2_fwd_wb");
        alu(5'd3, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t2_prod_a");
        alu(5'd3, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t2_prod_b");
        alu(5'd5, 5'd1, 5'd3, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t2_consumer2_id");
        nop(2'b00, 2'b10, 4'd0, "t2_mem_over_wb");
        nop(2'b00, 2'b00, 4'd0, "t2_drain0");
        nop(2'b00, 2'b00, 4'd0, "t2_drain1");

        // 3: load-use stalls one cycle, then forwards from WB
        lw(5'd2, 2'b00, 2'b00, 4'd0, "t3_load_id");
        alu(5'd6, 5'd2, 5'd2, 2'b00, 2'b00, 1'b1, 1'b1, 4'd0, "t3_stall");
        alu(5'd6, 5'd2, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1, "t3_bubble_in_ex");
        nop(2'b01, 2'b01, 4'd1, "t3_fwd_wb_after_stall");
        nop(2'b00, 2'b00, 4'd1, "t3_drain0");
        nop(2'b00, 2'b00, 4'd1, "t3_drain1");

        // 4: flush overrides load-use
        lw(5'd2, 2'b00, 2'b00, 4'd1, "t4_load_id");
        ciclo(1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1,
              1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 4'd1, "t4_flush_wins");
        nop(2'b00, 2'b00, 4'd1, "t4_flushed_bubble");
        nop(2'b00, 2'b00, 4'd1, "t4_drain0");
        nop(2'b00, 2'b00, 4'd1, "t4_drain1");

        // 5: register 0 never forwards and never stalls
        alu(5'd0, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1, "t5_w0_a");
        alu(5'd0, 5'd1, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1, "t5_w0_b");
        alu(5'd7, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1, "t5_reader_id");
        nop(2'b00, 2'b00, 4'd1, "t5_r0_no_fwd");
        lw(5'd0, 2'b00, 2'b00, 4'd1, "t5_lw_r0_id");
        alu(5'd7, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 4'd1, "t5_lw_r0_no_stall");
        nop(2'b00, 2'b00, 4'd1, "t5_drain0");
        nop(2'b00, 2'b00, 4'd1, "t5_drain1");

        // 6: reset during a stall cycle, then counter saturation
        lw(5'd2, 2'b00, 2'b00, 4'd1, "t6_load_id");
        reset = 1'b1;
        alu(5'd6, 5'd2, 5'd2, 2'b00, 2'b00, 1'b1, 1'b1, 4'd1, "t6_stall_with_reset");
        reset = 1'b0;
        alu(5'd6, 5'd2, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, "t6_after_reset");
        nop(2'b00, 2'b00, 4'd0, "t6_drain0");
        nop(2'b00, 2'b00, 4'd0, "t6_drain1");

        for (int i = 0; i < (1 << CW) + 1; i++) begin
            ciclo(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0,
                  1'b1, (i > 0) ? 2'b01 : 2'b00, (i > 0) ? 2'b01 : 2'b00,
                  1'b0, 1'b0, sat(i), "sat_load");
            alu(5'd6, 5'd2, 5'd2, 2'b00, 2'b00, 1'b1, 1'b1, sat(i), "sat_stall");
            alu(5'd6, 5'd2, 5'd2, 2'b00, 2'b00, 1'b0, 1'b0, sat(i + 1), "sat_bubble");
        end
        nop(2'b01, 2'b01, '1, "sat_hold_ffff");
        nop(2'b00, 2'b00, '1, "sat_final");

        checks++;
        if (cola.size() != 0) begin
            errors++;
            $display("FAIL queue_drained: got %0d pending, want 0", cola.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
